ans_decoder: RTL and testbench

ANS_DECODER -- requirements
Module: ans_decoder

---
 rtl/ans_decoder.sv | 172 +++++++++++++++++
 tb/tb_ans_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ans_decoder.sv
// rtl/ans_decoder.sv - rANS symbol decoder with programmable frequency table and byte-stream renormalisation
module ans_decoder #(
    parameter int SYM_WIDTH   = 2,
    parameter int PROB_BITS   = 4,
    parameter int STATE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   start,
    input  logic [15:0]            num_syms,
    input  logic                   cfg_we,
    input  logic [SYM_WIDTH-1:0]   cfg_sym,
    input  logic [PROB_BITS-1:0]   cfg_freq,
    input  logic [7:0]             in,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [SYM_WIDTH-1:0]   out,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int NSYM       = 1 << SYM_WIDTH;
    localparam int FREQ_RST_I = (1 << PROB_BITS) >> SYM_WIDTH;
    localparam logic [STATE_WIDTH-1:0] L_MIN = STATE_WIDTH'(1) << (STATE_WIDTH - 8);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        DECODE  = 3'd3,
        EMIT    = 3'd4,
        RENORM  = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t                  state;
    logic [STATE_WIDTH-1:0]  x;
    logic [15:0]             count;
    logic [PROB_BITS-1:0]    freq [NSYM];
    logic [PROB_BITS:0]      cum  [NSYM];

    logic [PROB_BITS-1:0]    slot;
    logic [SYM_WIDTH-1:0]    dec_sym;
    logic                    dec_hit;
    logic [STATE_WIDTH-1:0]  x_dec;
    logic [15:0]             count_dec;

    assign count_dec = count - 16'd1;

    // Running prefix sums of the frequency table (wraps if the table oversums)
    always_comb begin
        cum[0] = '0;
        for (int s = 1; s < NSYM; s++) begin
            cum[s] = cum[s-1] + {1'b0, freq[s-1]};
        end
    end

    // Slot lookup and next-state arithmetic; an empty slot falls back to the top symbol
    always_comb begin
        slot    = x[PROB_BITS-1:0];
        dec_sym = SYM_WIDTH'(NSYM - 1);
        dec_hit = 1'b0;
        for (int s = NSYM - 1; s >= 0; s--) begin
            if (({1'b0, cum[s]} <= {2'b00, slot}) &&
                ({2'b00, slot} < ({1'b0, cum[s]} + {2'b00, freq[s]}))) begin
                dec_sym = SYM_WIDTH'(s);
                dec_hit = 1'b1;
            end
        end
        x_dec = STATE_WIDTH'(freq[dec_sym]) * (x >> PROB_BITS)
              + STATE_WIDTH'(slot) - STATE_WIDTH'(cum[dec_sym]);
    end

    // Control FSM with registered handshake/status outputs and the frequency table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x       <= '0;
            count   <= '0;
            out     <= '0;
            out_vld <= 1'b0;
            in_rdy  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int s = 0; s < NSYM; s++) begin
                freq[s] <= PROB_BITS'(FREQ_RST_I);
            end
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        freq[cfg_sym] <= cfg_freq;
                    end
                    if (start && (num_syms != 16'd0)) begin
                        count  <= num_syms;
                        err    <= 1'b0;
                        state  <= LOAD_HI;
                        in_rdy <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LOAD_HI: begin
                    if (in_vld) begin
                        x     <= STATE_WIDTH'(in);
                        state <= LOAD_LO;
                    end
                end
                LOAD_LO: begin
                    if (in_vld) begin
                        x      <= {x[STATE_WIDTH-9:0], in};
                        in_rdy <= 1'b0;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    out     <= dec_sym;
                    x       <= x_dec;
                    out_vld <= 1'b1;
                    state   <= EMIT;
                    if (!dec_hit) begin
                        err <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_rdy) begin
                        count   <= count_dec;
                        out_vld <= 1'b0;
                        if (x < L_MIN) begin
                            in_rdy <= 1'b1;
                            state  <= RENORM;
                        end else if (count_dec == 16'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= DECODE;
                        end
                    end
                end
                RENORM: begin
                    if (in_vld) begin
                        x      <= {x[STATE_WIDTH-9:0], in};
                        in_rdy <= 1'b0;
                        if (count == 16'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= DECODE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    in_rdy  <= 1'b0;
                    out_vld <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ans_decoder.sv
// tb/tb_ans_decoder.sv - self-checking bench for ans_decoder: vector table, corner sequences, random streams vs reference model
module tb_ans_decoder;

    localparam int OPT_RAND    = 1;
    localparam int OPT_STALL   = 2;
    localparam int OPT_ENGAP   = 4;
    localparam int OPT_RESTART = 8;
    localparam int OPT_CFG     = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [15:0] num_syms;
    logic        cfg_we;
    logic [1:0]  cfg_sym;
    logic [3:0]  cfg_freq;
    logic [7:0]  in_byte;
    logic        in_vld;
    logic        in_rdy;
    logic [1:0]  out;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;
    logic        done;
    logic        err;

    ans_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .num_syms (num_syms),
        .cfg_we   (cfg_we),
        .cfg_sym  (cfg_sym),
        .cfg_freq (cfg_freq),
        .in       (in_byte),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out      (out),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0]  tbl [4];
    logic [7:0]  bytes_q [$];
    logic [1:0]  got_q [$];
    logic [15:0] xemit_q [$];
    int          exp_q [$];
    int          exp_x_q [$];
    int          exp_err;
    int          exp_consumed;
    int          exp_final_x;
    int          consumed;

    typedef struct {
        logic [3:0]  f0, f1, f2, f3;
        logic [15:0] x0;
        int          sym;
        int          e;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
        else n_pass++;
    endtask

    function automatic int cum_of(input int s);
        int c = 0;
        for (int j = 0; j < s; j++) c += tbl[j];
        return c % 32;
    endfunction

    // Reference: rANS decode of n symbols straight from the arithmetic rules
    task automatic model(input int n);
        int x, k, slot, s;
        exp_q.delete();
        exp_x_q.delete();
        exp_err = 0;
        x = (int'(bytes_q[0]) << 8) | int'(bytes_q[1]);
        k = 2;
        for (int i = 0; i < n; i++) begin
            slot = x % 16;
            s = -1;
            for (int j = 0; j < 4; j++)
                if (s < 0 && slot >= cum_of(j) && slot < cum_of(j) + tbl[j]) s = j;
            if (s < 0) begin
                s = 3;
                exp_err = 1;
            end
            x = (tbl[s] * (x / 16) + slot - cum_of(s)) & 32'hFFFF;
            exp_q.push_back(s);
            exp_x_q.push_back(x);
            if (x < 256) begin
                x = ((x << 8) | int'(bytes_q[k])) & 32'hFFFF;
                k++;
            end
        end
        exp_consumed = k;
        exp_final_x  = x;
    endtask

    task automatic prog_table();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            en = 1'b1; cfg_we = 1'b1; cfg_sym = 2'(s); cfg_freq = tbl[s];
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        en = 1'b1; start = 1'b1; num_syms = 16'(n); in_vld = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clr", err, 0);
        check("start_in_rdy", in_rdy, 1);
    endtask

    task automatic run_stream(input int n, input int opts);
        int cyc = 0, stall_n = 0, en_off = 0, idx = 0;
        bit seen_done = 0, first_vld = 0, first_rdy = 0, stalling = 0;
        bit en_v, iv, orv, st, cw;
        got_q.delete();
        xemit_q.delete();
        prog_table();
        model(n);
        pulse_start(n);
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen_done = 1;
                en = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; start = 1'b0; cfg_we = 1'b0;
                break;
            end
            en_v = 1; iv = 1; orv = 1; st = 0; cw = 0;
            if ((opts & OPT_RAND) != 0) begin
                en_v = ($urandom_range(0, 4) != 0);
                iv   = ($urandom_range(0, 2) != 0);
                orv  = ($urandom_range(0, 2) != 0);
            end
            if ((opts & OPT_CFG) != 0 && busy) begin
                cw = 1;
                cfg_sym  = 2'($urandom);
                cfg_freq = 4'($urandom);
            end
            if (!first_vld && out_vld) begin
                first_vld = 1;
                if ((opts & OPT_STALL) != 0) stalling = 1;
                if ((opts & OPT_RESTART) != 0) st = 1;
            end
            if (stalling) begin
                if (stall_n > 0) begin
                    check("stall_out", out, exp_q[0]);
                    check("stall_out_vld", out_vld, 1);
                    check("stall_in_rdy", in_rdy, 0);
                    check("stall_count", dut.count, n);
                end
                if (stall_n < 5) begin
                    orv = 0; en_v = 1; stall_n++;
                end else begin
                    stalling = 0;
                end
            end
            if (!first_rdy && in_rdy) begin
                first_rdy = 1;
                if ((opts & OPT_ENGAP) != 0) en_off = 4;
            end
            if (en_off > 0) begin
                if (en_off < 4) begin
                    check("engap_in_rdy", in_rdy, 1);
                    check("engap_busy", busy, 1);
                end
                en_v = 0; iv = 1; en_off--;
            end
            if (idx >= bytes_q.size()) iv = 0;
            en = en_v; in_vld = iv; out_rdy = orv; start = st; cfg_we = cw;
            num_syms = st ? 16'd7 : 16'(n);
            in_byte  = (idx < bytes_q.size()) ? bytes_q[idx] : 8'h00;
            if (en_v && iv && in_rdy) idx++;
            if (en_v && orv && out_vld) begin
                got_q.push_back(out);
                xemit_q.push_back(dut.x);
            end
        end
        consumed = idx;
        check("done_seen", seen_done, 1);
        check("nsyms", got_q.size(), n);
        if (got_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check("sym", got_q[i], exp_q[i]);
                check("x_emit", xemit_q[i], exp_x_q[i]);
            end
        end
        check("err", err, exp_err);
        check("consumed", idx, exp_consumed);
        check("final_x", dut.x, exp_final_x);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        for (int s = 0; s < 4; s++) check("table_kept", dut.freq[s], tbl[s]);
    endtask

    task automatic set_tbl(input logic [3:0] a, b, c, d);
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{4'd4, 4'd4, 4'd4, 4'd4,   16'h0100, 0, 0};
        vecs[1] = '{4'd4, 4'd4, 4'd4, 4'd4,   16'h1237, 1, 0};
        vecs[2] = '{4'd8, 4'd4, 4'd2, 4'd2,   16'hFFFD, 2, 0};
        vecs[3] = '{4'd4, 4'd4, 4'd4, 4'd0,   16'h010D, 3, 1};
        vecs[4] = '{4'd1, 4'd1, 4'd1, 4'd1,   16'h0009, 3, 1};
        vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd15,  16'h0005, 3, 0};
        vecs[6] = '{4'd15, 4'd0, 4'd0, 4'd0,  16'h000F, 3, 1};

        rst_n = 1'b0; en = 1'b0; start = 1'b0; num_syms = '0; cfg_we = 1'b0;
        cfg_sym = '0; cfg_freq = '0; in_byte = '0; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_x", dut.x, 0);
        check("rst_count", dut.count, 0);
        for (int s = 0; s < 4; s++) check("rst_freq", dut.freq[s], 4);
        rst_n = 1'b1;
        @(negedge clk);

        // Worked example: two symbols, one renormalisation byte
        set_tbl(4, 4, 4, 4);
        bytes_q = '{8'h01, 8'h00, 8'hAB};
        run_stream(2, 0);
        if (got_q.size() == 2) begin
            check("ex_sym0", got_q[0], 0);
            check("ex_sym1", got_q[1], 2);
            check("ex_x0", xemit_q[0], 16'h0040);
            check("ex_x1", xemit_q[1], 16'h102B);
        end
        check("ex_final_x", dut.x, 16'h102B);
        check("ex_consumed", consumed, 3);

        // Same stream with output back-pressure
        run_stream(2, OPT_STALL);

        // Zero-length start is ignored
        @(negedge clk);
        start = 1'b1; num_syms = 16'd0; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_busy", busy, 0);
        check("zero_in_rdy", in_rdy, 0);
        @(negedge clk);
        check("zero_busy2", busy, 0);

        // Start while busy is ignored
        run_stream(2, OPT_RESTART);

        // Vector table: single-symbol decodes including empty-slot errors
        for (int v = 0; v < 7; v++) begin
            set_tbl(vecs[v].f0, vecs[v].f1, vecs[v].f2, vecs[v].f3);
            bytes_q = '{vecs[v].x0[15:8], vecs[v].x0[7:0], 8'($urandom)};
            run_stream(1, 0);
            if (got_q.size() == 1) check("vec_sym", got_q[0], vecs[v].sym);
            check("vec_err", err, vecs[v].e);
        end

        // Enable gap while waiting for the first state byte
        set_tbl(4, 4, 4, 4);
        bytes_q = '{8'h01, 8'h00, 8'hAB};
        run_stream(2, OPT_ENGAP);

        // Table writes while busy are dropped
        set_tbl(3, 5, 6, 2);
        bytes_q = '{8'h7C, 8'h19, 8'h44, 8'h81, 8'h02, 8'hFE};
        run_stream(4, OPT_CFG);

        // Reset while a symbol is being offered
        set_tbl(1, 2, 3, 9);
        prog_table();
        pulse_start(3);
        in_byte = 8'h5A; in_vld = 1'b1; out_rdy = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (out_vld) seen = 1;
        end
        check("rst_reach_emit", seen, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_vld", out_vld, 0);
        check("arst_in_rdy", in_rdy, 0);
        check("arst_busy", busy, 0);
        check("arst_out", out, 0);
        for (int s = 0; s < 4; s++) check("arst_freq", dut.freq[s], 4);
        @(negedge clk);
        rst_n = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        check("arst_stay_idle", busy, 0);

        // Randomized streams against the reference model
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) set_tbl(4, 4, 4, 4);
            else set_tbl(4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)),
                         4'($urandom_range(0, 10)), 4'($urandom_range(0, 15)));
            bytes_q.delete();
            for (int b = 0; b < n + 2; b++) bytes_q.push_back(8'($urandom));
            run_stream(n, OPT_RAND | (($urandom_range(0, 1) == 1) ? OPT_CFG : 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
